// File: rtl/sdram_demo_memtest_master_if.sv
// Avalon-MM bus between the memory-test master and the on-chip RAM slave port.
interface sdram_demo_memtest_master_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              clken;
    logic [31:0]       readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/sdram_demo_memtest_master.sv
// Bring-up memory checker: fills a word range with a pattern, reads it back
// and counts mismatches. Optional macro MEMTEST_LFSR_EN swaps the incrementing
// pattern for a 32-bit Galois LFSR sequence.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | strobes low, waiting for start
// S_WRITE | one write per cycle, base+i <= P(i)
// S_READ  | one read per cycle, expected word pushed into compare pipeline
// S_DRAIN | strobes low, last reads still in flight
// S_DONE  | one-cycle done pulse, pass is valid
module sdram_demo_memtest_master #(
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base,
    input  logic [ADDR_W:0]           length,
    input  logic [31:0]               seed,
    sdram_demo_memtest_master_if.master bus,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               err_count,
    output logic [ADDR_W-1:0]         first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [31:0]       seed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [31:0]       pat_q;

    logic [READ_LATENCY-1:0] exp_vld;
    logic [ADDR_W-1:0]       exp_addr [READ_LATENCY];
    logic [31:0]             exp_data [READ_LATENCY];

    logic load_start, load_read, advance, issue_rd, enter_done;
    logic pipe_pending, mismatch;
    logic last_item;

    function automatic logic [31:0] pat_first(input logic [31:0] s);
`ifdef MEMTEST_LFSR_EN
        // An all-zero LFSR state would lock up, so seed 0 starts at 1.
        return (s == 32'd0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] pat_next(input logic [31:0] p);
`ifdef MEMTEST_LFSR_EN
        return p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
        return p + 32'd1;
`endif
    endfunction

    assign last_item = (remain_q == (ADDR_W+1)'(1));

    // Anything still in flight ahead of the entry being compared this cycle.
    always_comb begin
        pipe_pending = 1'b0;
        for (int k = 0; k < READ_LATENCY - 1; k++) begin
            pipe_pending = pipe_pending | exp_vld[k];
        end
    end

    assign mismatch = exp_vld[READ_LATENCY-1] &&
                      (bus.readdata != exp_data[READ_LATENCY-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        load_read  = 1'b0;
        advance    = 1'b0;
        issue_rd   = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    state_d    = (length == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                advance = 1'b1;
                if (last_item) begin
                    load_read = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                advance  = 1'b1;
                issue_rd = 1'b1;
                if (last_item) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_pending) begin
                    enter_done = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address/pattern generator and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            addr_q         <= '0;
            remain_q       <= '0;
            pat_q          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else if (load_start) begin
            base_q         <= base;
            len_q          <= length;
            seed_q         <= seed;
            addr_q         <= base;
            remain_q       <= length;
            pat_q          <= pat_first(seed);
            err_count      <= '0;
            first_err_addr <= '0;
            // A zero-length test goes straight to DONE and trivially passes.
            pass           <= (length == '0);
        end else begin
            if (load_read) begin
                addr_q   <= base_q;
                remain_q <= len_q;
                pat_q    <= pat_first(seed_q);
            end else if (advance) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
                pat_q    <= pat_next(pat_q);
            end
            if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'd0) begin
                    first_err_addr <= exp_addr[READ_LATENCY-1];
                end
            end
            // The final compare can land on the same edge as the DRAIN exit.
            if (enter_done) begin
                pass <= (err_count == 16'd0) && !mismatch;
            end
        end
    end

    // Expect pipeline, aligned with the slave's read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                exp_addr[k] <= '0;
                exp_data[k] <= '0;
            end
        end else begin
            exp_vld[0]  <= issue_rd;
            exp_addr[0] <= addr_q;
            exp_data[0] <= pat_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                exp_vld[k]  <= exp_vld[k-1];
                exp_addr[k] <= exp_addr[k-1];
                exp_data[k] <= exp_data[k-1];
            end
        end
    end

    assign bus.chipselect = (state_q == S_WRITE) || (state_q == S_READ);
    assign bus.write      = (state_q == S_WRITE);
    assign bus.byteenable = bus.chipselect ? 4'hF : 4'h0;
    assign bus.address    = addr_q;
    assign bus.writedata  = pat_q;
    assign bus.clken      = 1'b1;

    assign busy = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_sdram_demo_memtest_master.sv
// Scoreboard bench for sdram_demo_memtest_master: a RAM model with optional
// fault injection, expected bus traffic and results queued per test.
module tb_sdram_demo_memtest_master;
    localparam int AW = 14;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   length = '0;
    logic [31:0]   seed = '0;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    sdram_demo_memtest_master_if #(.ADDR_W(AW)) bus ();

    sdram_demo_memtest_master #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base           (base),
        .length         (length),
        .seed           (seed),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // RAM model: registered read data, one word optionally forced bad.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   rd_q = '0;
    logic          force_en = 1'b0;
    logic [AW-1:0] force_addr = '0;
    always @(posedge clk) begin
        if (bus.chipselect && bus.write) mem[bus.address] <= bus.writedata;
        if (bus.chipselect && !bus.write)
            rd_q <= (force_en && bus.address == force_addr) ? 32'hDEAD_BEEF : mem[bus.address];
    end
    assign bus.readdata = rd_q;

    typedef struct {
        int          lat;
        int          nbusy;
        int          ncs;
        logic [15:0] err;
        logic [AW-1:0] fa;
        logic        pass;
    } res_t;

    logic [AW+31:0] wr_q [$];
    logic [AW-1:0]  rd_addr_q [$];
    res_t           res_q [$];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_done = 0;
    logic tstart = 1'b0;
    logic chk_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] model_first(input logic [31:0] s);
`ifdef MEMTEST_LFSR_EN
        return (s == 0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p);
`ifdef MEMTEST_LFSR_EN
        return (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'd0);
`else
        return p + 1;
`endif
    endfunction

    // Expected bus traffic and results for a test from the spec's rules.
    task automatic push_expect(input logic [AW-1:0] b, input int l, input logic [31:0] s,
                               input bit fen, input logic [AW-1:0] fa);
        logic [31:0]   p;
        logic [AW-1:0] a;
        res_t          r;
        int            errs;
        p = model_first(s);
        errs = 0;
        r.fa = '0;
        for (int i = 0; i < l; i++) begin
            a = b + AW'(i);
            wr_q.push_back({a, p});
            rd_addr_q.push_back(a);
            if (fen && a == fa && p != 32'hDEAD_BEEF) begin
                if (errs == 0) r.fa = a;
                errs++;
            end
            p = model_next(p);
        end
        r.err   = (errs > 65535) ? 16'hFFFF : 16'(errs);
        r.pass  = (errs == 0);
        r.lat   = (l == 0) ? 1 : 2 * l + RL + 1;
        r.nbusy = (l == 0) ? 0 : 2 * l + RL;
        r.ncs   = 2 * l;
        res_q.push_back(r);
    endtask

    task automatic wait_done(input int n0, input int limit);
        int cnt;
        cnt = 0;
        while (n_done == n0 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        if (n_done == n0) begin
            fail_now("done_timeout");
            wr_q.delete();
            rd_addr_q.delete();
            res_q.delete();
        end
    endtask

    task automatic run_test(input logic [AW-1:0] b, input int l, input logic [31:0] s,
                            input bit fen, input logic [AW-1:0] fa, input bit poke);
        int n0;
        push_expect(b, l, s, fen, fa);
        n0 = n_done;
        @(negedge clk);
        force_en = fen;
        force_addr = fa;
        base = b;
        length = (AW+1)'(l);
        seed = s;
        start = 1'b1;
        tstart = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tstart = 1'b0;
        if (poke) begin
            // A start while busy must be ignored.
            repeat (2) @(negedge clk);
            base = ~b;
            length = 5;
            seed = ~s;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(n0, 2 * l + 40);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents an access or done.
    int since = 0;
    int bcnt = 0;
    int ncs = 0;
    initial begin
        logic [AW+31:0] e;
        logic [AW-1:0]  ea;
        res_t           r;
        forever begin
            @(posedge clk);
            #1;
            if (tstart) begin
                since = 1;
                bcnt = 0;
                ncs = 0;
            end else begin
                since++;
            end
            if (busy) bcnt++;
            if (chk_en && !reset) begin
                if (bus.chipselect) begin
                    ncs++;
                    chk("byteenable", 64'(bus.byteenable), 64'hF);
                    if (bus.write) begin
                        if (wr_q.size() == 0) fail_now("unexpected_write");
                        else begin
                            e = wr_q.pop_front();
                            chk("wr_addr", 64'(bus.address), 64'(e[AW+31:32]));
                            chk("wr_data", 64'(bus.writedata), 64'(e[31:0]));
                        end
                    end else begin
                        if (rd_addr_q.size() == 0) fail_now("unexpected_read");
                        else begin
                            ea = rd_addr_q.pop_front();
                            chk("rd_addr", 64'(bus.address), 64'(ea));
                        end
                    end
                end
                if (done) begin
                    if (res_q.size() == 0) fail_now("unexpected_done");
                    else begin
                        r = res_q.pop_front();
                        chk("done_latency", 64'(since), 64'(r.lat));
                        chk("busy_cycles", 64'(bcnt), 64'(r.nbusy));
                        chk("access_count", 64'(ncs), 64'(r.ncs));
                        chk("err_count", 64'(err_count), 64'(r.err));
                        chk("first_err_addr", 64'(first_err_addr), 64'(r.fa));
                        chk("pass", 64'(pass), 64'(r.pass));
                    end
                end
            end
            if (done) n_done++;
        end
    end

    initial begin
        logic [AW-1:0] b, fa;
        int            l;
        bit            fen;
        int            n0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_chipselect", 64'(bus.chipselect), 64'd0);
        chk("rst_write", 64'(bus.write), 64'd0);
        chk("rst_byteenable", 64'(bus.byteenable), 64'd0);
        chk("rst_address", 64'(bus.address), 64'd0);
        chk("rst_writedata", 64'(bus.writedata), 64'd0);
        chk("rst_clken", 64'(bus.clken), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_first_err", 64'(first_err_addr), 64'd0);

        // Directed cases.
        run_test(14'd0, 4, 32'h1000, 1'b0, 14'd0, 1'b0);
        run_test(14'd0, 8, 32'h1234_5678, 1'b1, 14'd2, 1'b0);
        run_test(14'd16383, 3, 32'hCAFE_0000, 1'b0, 14'd0, 1'b0);
        run_test(14'd16383, 3, 32'h0000_0010, 1'b1, 14'd0, 1'b0);
        run_test(14'd77, 0, 32'h5555_AAAA, 1'b0, 14'd0, 1'b0);
        run_test(14'd500, 0, 32'h0, 1'b1, 14'd500, 1'b0);
        run_test(14'd40, 6, 32'h0, 1'b0, 14'd0, 1'b0);
        run_test(14'd300, 12, 32'hFFFF_FFFE, 1'b1, 14'd311, 1'b1);

        // Reset in the middle of READ aborts the test cleanly.
        chk_en = 1'b0;
        n0 = n_done;
        @(negedge clk);
        force_en = 1'b1;
        force_addr = 14'd100;
        base = 14'd100;
        length = 10;
        seed = 32'h0BAD_F00D;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("midread_busy", 64'(busy), 64'd1);
        chk("midread_is_read", 64'({bus.chipselect, bus.write}), 64'b10);
        chk("midread_err_count", 64'(err_count), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_chipselect", 64'(bus.chipselect), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_err_count", 64'(err_count), 64'd0);
        chk("abort_first_err", 64'(first_err_addr), 64'd0);
        reset = 1'b0;
        force_en = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(n_done - n0), 64'd0);
        run_test(14'd100, 10, 32'h0BAD_F00D, 1'b0, 14'd0, 1'b0);

        // Randomized tests.
        for (int t = 0; t < 24; t++) begin
            b   = AW'($urandom);
            l   = $urandom_range(1, 40);
            fen = 1'($urandom_range(0, 1));
            fa  = ($urandom_range(0, 3) != 0) ? AW'(b + AW'($urandom_range(0, l - 1))) : AW'($urandom);
            run_test(b, l, $urandom, fen, fa, 1'($urandom_range(0, 3) == 0));
        end

        // Whole address space once, wrapping from a random base.
        b = AW'($urandom);
        run_test(b, 1 << AW, $urandom, 1'b1, AW'(b - 14'd1), 1'b0);

        chk("leftover_writes", 64'(wr_q.size()), 64'd0);
        chk("leftover_reads", 64'(rd_addr_q.size()), 64'd0);
        chk("leftover_results", 64'(res_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
